ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage. Forwarding muxes, ALU and the EX/MEM pipeline register.
// Latency: 1 cycle for every op. With EX_STAGE_SEQ_MUL_EN, mul stays in EX for 33 cycles (T..T+32).
// Backpressure: accepts none downstream. stall_o (combinational) freezes PC, IF/ID and ID/EX while a sequential mul runs.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), async active-high reset
//   *_i from ID/EX           controls, ALUOp/funct, register data, imm, register addresses, valid
//   MEM_* / WB_*             forwarding sources (write enable, rd address, data)
//   flush_i                  kills the instruction in EX, including a multiply in progress
//   *_o to EX/MEM            registered controls, alu_result, store_data, rd_addr, valid
//   stall_o                  combinational pipeline freeze
//
// Config: define EX_STAGE_SEQ_MUL_EN to replace the single-cycle multiplier with a
//         32-iteration shift-add unit that stalls the front end.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        valid_i,
  input  logic        MEM_RegWrite_i,
  input  logic [4:0]  MEM_rd_addr_i,
  input  logic [31:0] MEM_data_i,
  input  logic        WB_RegWrite_i,
  input  logic [4:0]  WB_rd_addr_i,
  input  logic [31:0] WB_data_i,
  input  logic        flush_i,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        valid_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        stall_o
);

  // {funct7, funct3} encodings
  localparam logic [9:0] F_ADD  = 10'b0000000_000;
  localparam logic [9:0] F_SUB  = 10'b0100000_000;
  localparam logic [9:0] F_SLL  = 10'b0000000_001;
  localparam logic [9:0] F_XOR  = 10'b0000000_100;
  localparam logic [9:0] F_AND  = 10'b0000000_111;
  localparam logic [9:0] F_MUL  = 10'b0000001_000;
  localparam logic [9:0] F_SRAI = 10'b0100000_101;
  localparam logic [2:0] F3_ADDI = 3'b000;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
  } exmem_t;

  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  exmem_t      dp_out;
  exmem_t      out_d;
  exmem_t      out_q;

  // Forwarding: MEM is the younger producer, so it wins over WB. x0 never forwards.
  always_comb begin
    if (MEM_RegWrite_i && (MEM_rd_addr_i != 5'd0) && (MEM_rd_addr_i == rs1_addr_i))
      rs1_fwd = MEM_data_i;
    else if (WB_RegWrite_i && (WB_rd_addr_i != 5'd0) && (WB_rd_addr_i == rs1_addr_i))
      rs1_fwd = WB_data_i;
    else
      rs1_fwd = rs1_data_i;
  end

  always_comb begin
    if (MEM_RegWrite_i && (MEM_rd_addr_i != 5'd0) && (MEM_rd_addr_i == rs2_addr_i))
      rs2_fwd = MEM_data_i;
    else if (WB_RegWrite_i && (WB_rd_addr_i != 5'd0) && (WB_rd_addr_i == rs2_addr_i))
      rs2_fwd = WB_data_i;
    else
      rs2_fwd = rs2_data_i;
  end

  assign op_a = rs1_fwd;
  assign op_b = ALUSrc_i ? imm_i : rs2_fwd;

  // ALU. Undecoded combinations give 0; the controls still pass through.
  always_comb begin
    alu_res = '0;
    case (ALUOp_i)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (funct_i)
          F_AND:   alu_res = op_a & op_b;
          F_XOR:   alu_res = op_a ^ op_b;
          F_SLL:   alu_res = op_a << op_b[4:0];
          F_ADD:   alu_res = op_a + op_b;
          F_SUB:   alu_res = op_a - op_b;
`ifndef EX_STAGE_SEQ_MUL_EN
          F_MUL:   alu_res = op_a * op_b;
`endif
          default: alu_res = '0;
        endcase
      end
      default: begin
        // The I-type shift amount always comes from imm[4:0]. The upper imm bits carry funct7.
        if (funct_i[2:0] == F3_ADDI)
          alu_res = op_a + op_b;
        else if (funct_i == F_SRAI)
          alu_res = $signed(op_a) >>> imm_i[4:0];
      end
    endcase
  end

  // Single-cycle datapath result. An invalid or flushed slot becomes an all-zero bubble.
  always_comb begin
    dp_out = '0;
    if (valid_i && !flush_i) begin
      dp_out.reg_write  = RegWrite_i;
      dp_out.mem_to_reg = MemtoReg_i;
      dp_out.mem_read   = MemRead_i;
      dp_out.mem_write  = MemWrite_i;
      dp_out.valid      = 1'b1;
      dp_out.alu_result = alu_res;
      dp_out.store_data = rs2_fwd;
      dp_out.rd_addr    = rd_addr_i;
    end
  end

`ifdef EX_STAGE_SEQ_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  // Controls of the multiply in flight. They are re-emitted with the product.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
  } mctl_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  mctl_t       lat_q, lat_d;
  logic        is_mul;
  logic        stall;
  logic [31:0] acc_sum;

  assign is_mul  = valid_i && (ALUOp_i == 2'b10) && (funct_i == F_MUL);
  // One shift-add step: add the multiplicand (already shifted by cnt) when the current multiplier LSB is set.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      lat_q    <= lat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    lat_d    = lat_q;
    out_d    = dp_out;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mul && !flush_i) begin
          stall    = 1'b1;
          state_d  = BUSY;
          cnt_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          lat_d.reg_write  = RegWrite_i;
          lat_d.mem_to_reg = MemtoReg_i;
          lat_d.mem_read   = MemRead_i;
          lat_d.mem_write  = MemWrite_i;
          lat_d.store_data = rs2_fwd;
          lat_d.rd_addr    = rd_addr_i;
          out_d    = '0;
        end
      end
      default: begin
        // BUSY ignores ID/EX. Only flush is honoured, and it wins over completion.
        out_d = '0;
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          // Drop the stall in the last iteration so ID/EX moves on at the same edge as the product.
          stall    = (cnt_q != 5'd31);
          if (cnt_q == 5'd31) begin
            state_d          = IDLE;
            out_d.reg_write  = lat_q.reg_write;
            out_d.mem_to_reg = lat_q.mem_to_reg;
            out_d.mem_read   = lat_q.mem_read;
            out_d.mem_write  = lat_q.mem_write;
            out_d.valid      = 1'b1;
            out_d.alu_result = acc_sum;
            out_d.store_data = lat_q.store_data;
            out_d.rd_addr    = lat_q.rd_addr;
          end
        end
      end
    endcase
  end

  assign stall_o = stall && !rst_i;
`else
  assign out_d   = dp_out;
  assign stall_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) out_q <= '0;
    else       out_q <= out_d;
  end

  assign RegWrite_o   = out_q.reg_write;
  assign MemtoReg_o   = out_q.mem_to_reg;
  assign MemRead_o    = out_q.mem_read;
  assign MemWrite_o   = out_q.mem_write;
  assign valid_o      = out_q.valid;
  assign alu_result_o = out_q.alu_result;
  assign store_data_o = out_q.store_data;
  assign rd_addr_o    = out_q.rd_addr;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table and scoreboard bench for ex_stage.
// Latency: outputs are sampled 1 ns after each rising edge. stall_o is sampled mid-cycle.
// Backpressure: none; multiply sequences are only compiled with EX_STAGE_SEQ_MUL_EN.
`timescale 1ns/1ps
module tb_ex_stage;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [9:0]  funct_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        valid_i;
  logic        MEM_RegWrite_i;
  logic [4:0]  MEM_rd_addr_i;
  logic [31:0] MEM_data_i;
  logic        WB_RegWrite_i;
  logic [4:0]  WB_rd_addr_i;
  logic [31:0] WB_data_i;
  logic        flush_i;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, valid_o;
  logic [31:0] alu_result_o, store_data_o;
  logic [4:0]  rd_addr_o;
  logic        stall_o;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i), .funct_i(funct_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .valid_i(valid_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_rd_addr_i(MEM_rd_addr_i), .MEM_data_i(MEM_data_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_rd_addr_i(WB_rd_addr_i), .WB_data_i(WB_data_i),
    .flush_i(flush_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .valid_o(valid_o), .alu_result_o(alu_result_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctl;     // {RegWrite, MemtoReg, MemRead, MemWrite}
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [9:0]  funct;
    logic        alusrc;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, imm;
    logic        valid, flush;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [3:0]  ctl;
    exp_t        exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    chk({name, ".valid"}, {31'b0, valid_o}, {31'b0, e.valid});
    chk({name, ".ctl"}, {28'b0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, {28'b0, e.ctl});
    chk({name, ".result"}, alu_result_o, e.res);
    chk({name, ".store"}, store_data_o, e.store);
    chk({name, ".rd"}, {27'b0, rd_addr_o}, {27'b0, e.rd});
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] op, input logic [9:0] fn,
                              input logic src, input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [3:0] ctl, input logic [31:0] res);
    vec_t v;
    v.name = nm; v.aluop = op; v.funct = fn; v.alusrc = src;
    v.rs1a = a1; v.rs1d = d1; v.rs2a = a2; v.rs2d = d2; v.imm = imm; v.rd = rd; v.ctl = ctl;
    v.valid = 1'b1; v.flush = 1'b0;
    v.mwe = 1'b0; v.mrd = '0; v.mdat = '0;
    v.wwe = 1'b0; v.wrd = '0; v.wdat = '0;
    v.exp.valid = 1'b1; v.exp.ctl = ctl; v.exp.res = res; v.exp.store = d2; v.exp.rd = rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ALUOp_i = v.aluop; funct_i = v.funct; ALUSrc_i = v.alusrc;
    rs1_addr_i = v.rs1a; rs1_data_i = v.rs1d; rs2_addr_i = v.rs2a; rs2_data_i = v.rs2d;
    imm_i = v.imm; rd_addr_i = v.rd;
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = v.ctl;
    valid_i = v.valid; flush_i = v.flush;
    MEM_RegWrite_i = v.mwe; MEM_rd_addr_i = v.mrd; MEM_data_i = v.mdat;
    WB_RegWrite_i = v.wwe; WB_rd_addr_i = v.wrd; WB_data_i = v.wdat;
  endtask

`ifdef EX_STAGE_SEQ_MUL_EN
  // Runs one mul from cycle T (k=0) to T+34. flush_k / rst_k pick the cycle of a flush or reset pulse (-1 = none).
  task automatic mul_seq(input string nm, input int flush_k, input int rst_k);
    vec_t m, j, z;
    exp_t e;
    bit   dead, exp_stall;
    m = mk("mul", 2'b10, 10'b0000001_000, 1'b0, 5'd1, 32'h0001_0003, 5'd2, 32'h0000_0010,
           32'd0, 5'd8, 4'b1000, 32'h0010_0030);
    j = mk("junk", 2'b10, 10'b0000000_000, 1'b0, 5'd3, 32'h77, 5'd4, 32'h88, 32'd0, 5'd9, 4'b1000, 32'hFF);
    z = m;
    z.valid = 1'b0;
    dead = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      if (k == 0) drive(m);
      else if (!dead && k <= 32) drive(j);
      else drive(z);
      if (k == flush_k) flush_i = 1'b1;
      if (k == rst_k) begin
        #2 rst_i = 1'b1;
        #1;
        sb.push_back('0);
        check_pop($sformatf("%s.rst_k%0d", nm, k));
        chk($sformatf("%s.rst_stall", nm), {31'b0, stall_o}, 32'd0);
        dead = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        continue;
      end
      e = '0;
      exp_stall = 1'b0;
      if (!dead && k != flush_k) begin
        exp_stall = (k <= 31);
        if (k == 32) begin
          e.valid = 1'b1; e.ctl = 4'b1000; e.res = 32'h0010_0030; e.store = 32'h10; e.rd = 5'd8;
        end
      end
      if (k == flush_k) dead = 1'b1;
      sb.push_back(e);
      #4 chk($sformatf("%s.stall_k%0d", nm, k), {31'b0, stall_o}, {31'b0, exp_stall});
      @(posedge clk_i);
      #1 check_pop($sformatf("%s.k%0d", nm, k));
    end
    flush_i = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] a, b;
    logic        is_sub;

    // Vector table.
    vecs.push_back(mk("add_r", 2'b10, 10'b0000000_000, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 4'b1000, 32'd12));
    vecs.push_back(mk("ld_add", 2'b00, 10'b0, 1'b1, 5'd5, 32'h100, 5'd6, 32'h55, 32'h8, 5'd7, 4'b1110, 32'h108));
    v = mk("fwd_mem", 2'b11, 10'b0, 1'b1, 5'd4, 32'h1111, 5'd0, 32'd0, 32'd1, 5'd5, 4'b1000, 32'hAAAB);
    v.mwe = 1; v.mrd = 5'd4; v.mdat = 32'hAAAA; v.wwe = 1; v.wrd = 5'd4; v.wdat = 32'hBBBB;
    vecs.push_back(v);
    v = mk("fwd_wb", 2'b11, 10'b0, 1'b1, 5'd4, 32'h1111, 5'd0, 32'd0, 32'd1, 5'd5, 4'b1000, 32'hBBBC);
    v.mwe = 1; v.mrd = 5'd5; v.mdat = 32'hAAAA; v.wwe = 1; v.wrd = 5'd4; v.wdat = 32'hBBBB;
    vecs.push_back(v);
    v = mk("fwd_rd0", 2'b11, 10'b0, 1'b1, 5'd4, 32'h1111, 5'd0, 32'd0, 32'd1, 5'd5, 4'b1000, 32'h1112);
    v.mwe = 1; v.mrd = 5'd0; v.mdat = 32'hAAAA; v.wwe = 1; v.wrd = 5'd0; v.wdat = 32'hBBBB;
    vecs.push_back(v);
    v = mk("fwd_x0", 2'b11, 10'b0, 1'b1, 5'd0, 32'h1111, 5'd0, 32'd0, 32'd1, 5'd5, 4'b1000, 32'h1112);
    v.mwe = 1; v.mrd = 5'd0; v.mdat = 32'hAAAA; v.wwe = 1; v.wrd = 5'd0; v.wdat = 32'hBBBB;
    vecs.push_back(v);
    v = mk("fwd_off", 2'b11, 10'b0, 1'b1, 5'd4, 32'h1111, 5'd0, 32'd0, 32'd1, 5'd5, 4'b1000, 32'h1112);
    v.mwe = 0; v.mrd = 5'd4; v.mdat = 32'hAAAA; v.wwe = 0; v.wrd = 5'd4; v.wdat = 32'hBBBB;
    vecs.push_back(v);
    v = mk("sub_r_wb", 2'b10, 10'b0100000_000, 1'b0, 5'd10, 32'd10, 5'd6, 32'h99, 32'd0, 5'd11, 4'b1000, 32'd7);
    v.wwe = 1; v.wrd = 5'd6; v.wdat = 32'd3; v.mwe = 1; v.mrd = 5'd7; v.mdat = 32'hFFFF; v.exp.store = 32'd3;
    vecs.push_back(v);
    vecs.push_back(mk("srai", 2'b11, 10'b0100000_101, 1'b1, 5'd1, 32'h8000_0000, 5'd0, 32'd0, 32'h0000_0404, 5'd12, 4'b1000, 32'hF800_0000));
    vecs.push_back(mk("sub_b", 2'b01, 10'b0, 1'b0, 5'd1, 32'd3, 5'd2, 32'd5, 32'd0, 5'd0, 4'b0000, 32'hFFFF_FFFE));
    vecs.push_back(mk("and", 2'b10, 10'b0000000_111, 1'b0, 5'd1, 32'hF0F0_1234, 5'd2, 32'h0FF0_FFFF, 32'd0, 5'd13, 4'b1000, 32'h00F0_1234));
    vecs.push_back(mk("xor", 2'b10, 10'b0000000_100, 1'b0, 5'd1, 32'hFFFF_0000, 5'd2, 32'h0F0F_0F0F, 32'd0, 5'd13, 4'b1000, 32'hF0F0_0F0F));
    vecs.push_back(mk("sll", 2'b10, 10'b0000000_001, 1'b0, 5'd1, 32'd1, 5'd2, 32'h23, 32'd0, 5'd13, 4'b1000, 32'd8));
    vecs.push_back(mk("add_ovf", 2'b10, 10'b0000000_000, 1'b0, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd2, 32'd0, 5'd13, 4'b1000, 32'd1));
    vecs.push_back(mk("undec_r", 2'b10, 10'b0000000_010, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd14, 4'b1000, 32'd0));
    vecs.push_back(mk("undec_i", 2'b11, 10'b0000000_101, 1'b1, 5'd1, 32'h80, 5'd2, 32'd7, 32'd4, 5'd14, 4'b1000, 32'd0));
    v = mk("store_fwd", 2'b00, 10'b0, 1'b1, 5'd1, 32'h1000, 5'd9, 32'h1234, 32'h10, 5'd0, 4'b0001, 32'h1010);
    v.mwe = 1; v.mrd = 5'd9; v.mdat = 32'hDEAD_BEEF; v.exp.store = 32'hDEAD_BEEF;
    vecs.push_back(v);
    v = mk("invalid", 2'b10, 10'b0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 4'b1111, 32'd12);
    v.valid = 0; v.exp = '0;
    vecs.push_back(v);
    v = mk("flush", 2'b10, 10'b0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 4'b1111, 32'd12);
    v.flush = 1; v.exp = '0;
    vecs.push_back(v);
`ifndef EX_STAGE_SEQ_MUL_EN
    vecs.push_back(mk("mul", 2'b10, 10'b0000001_000, 1'b0, 5'd1, 32'h0001_0003, 5'd2, 32'h0000_0010, 32'd0, 5'd8, 4'b1000, 32'h0010_0030));
    vecs.push_back(mk("mul_ovf", 2'b10, 10'b0000001_000, 1'b0, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 32'd0, 5'd8, 4'b1000, 32'd1));
`endif
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      is_sub = ($urandom_range(0, 1) == 1);
      vecs.push_back(mk($sformatf("rnd%0d", i), is_sub ? 2'b01 : 2'b00, 10'b0, 1'b0, 5'd20, a, 5'd21, b,
                        32'd0, 5'd22, 4'b1000, is_sub ? (a - b) : (a + b)));
    end

    // Reset: outputs zero and stall low even with a mul presented.
    v = mk("rst_mul", 2'b10, 10'b0000001_000, 1'b0, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 5'd8, 4'b1000, 32'd0);
    drive(v);
    rst_i = 1'b1;
    #2;
    sb.push_back('0);
    check_pop("reset");
    chk("reset.stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    sb.push_back('0);
    check_pop("reset_edge");
    v.valid = 1'b0;
    drive(v);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      sb.push_back(vecs[i].exp);
      #4 chk({vecs[i].name, ".stall"}, {31'b0, stall_o}, 32'd0);
      @(posedge clk_i);
      #1 check_pop(vecs[i].name);
    end

    // Asynchronous reset clears registered outputs without waiting for an edge.
    drive(vecs[0]);
    sb.push_back(vecs[0].exp);
    @(posedge clk_i);
    #1 check_pop("pre_async_rst");
    rst_i = 1'b1;
    #1;
    sb.push_back('0);
    check_pop("async_rst");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

`ifdef EX_STAGE_SEQ_MUL_EN
    mul_seq("mul_plain", -1, -1);
    mul_seq("mul_flush10", 10, -1);
    mul_seq("mul_flush_issue", 0, -1);
    mul_seq("mul_flush_last", 32, -1);
    mul_seq("mul_rst5", -1, 5);
    mul_seq("mul_again", -1, -1);
    drive(vecs[0]);
    sb.push_back(vecs[0].exp);
    #4 chk("after_mul.stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i);
    #1 check_pop("after_mul");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
